// File: rtl/camera_capture_pkg.sv
// Shared state encoding, RGB332 colour constants and pixel conversion for the camera capture stage.
package camera_capture_pkg;

   typedef enum logic [2:0] {
      ST_SYNC    = 3'd0,
      ST_VBLANK  = 3'd1,
      ST_HBLANK  = 3'd2,
      ST_BYTE_HI = 3'd3,
      ST_BYTE_LO = 3'd4
   } cap_state_t;

   localparam int DEF_SCREEN_WIDTH  = 176;
   localparam int DEF_SCREEN_HEIGHT = 144;

   localparam logic [7:0] RED   = 8'hE0;
   localparam logic [7:0] GREEN = 8'h1C;
   localparam logic [7:0] BLUE  = 8'h03;
   localparam logic [7:0] WHITE = 8'hFF;

   // Keeps the top bits of each RGB565 channel: R[4:2], G[5:3], B[4:3].
   function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] hi, input logic [7:0] lo);
      return {hi[7:5], hi[2:0], lo[4:3]};
   endfunction

endpackage

// File: rtl/camera_capture_pattern.sv
// Eight vertical colour bars selected from the current column; used only when
// CAMERA_CAPTURE_TEST_PATTERN_EN is defined.
module camera_capture_pattern
   import camera_capture_pkg::*;
#(
   parameter int SCREEN_WIDTH = DEF_SCREEN_WIDTH,
   parameter int X_W          = 8
) (
   input  logic [X_W-1:0] x_s,
   output logic [7:0]     pixel_s
);
   localparam int BAR_W = SCREEN_WIDTH / 8;

   logic [2:0] bar_s;

   assign bar_s = 3'(x_s / X_W'(BAR_W));

   // Bar index to RGB332 colour.
   always_comb begin
      pixel_s = 8'h00;
      case (bar_s)
         3'd0:    pixel_s = WHITE;
         3'd1:    pixel_s = RED;
         3'd2:    pixel_s = GREEN;
         3'd3:    pixel_s = BLUE;
         3'd4:    pixel_s = 8'hFC;
         3'd5:    pixel_s = 8'h1F;
         3'd6:    pixel_s = 8'hE3;
         default: pixel_s = 8'h00;
      endcase
   end

endmodule

// File: rtl/camera_capture.sv
// OV7670 capture front end: pairs RGB565 bytes, converts to RGB332, crops and writes the frame buffer.
// Defining CAMERA_CAPTURE_TEST_PATTERN_EN replaces pixel content with colour bars.
module camera_capture
   import camera_capture_pkg::*;
#(
   parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
   parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
   parameter int ADDR_W        = 15
) (
   input  logic              CLK,
   input  logic              RESET_NEG,
   input  logic              VSYNC,
   input  logic              HREF,
   input  logic [7:0]        CAM_DATA,
   output logic [7:0]        PIXEL_OUT,
   output logic [ADDR_W-1:0] W_ADDR,
   output logic              W_EN,
   output logic              FRAME_DONE,
   output logic [7:0]        FRAME_LINES
);
   localparam int X_W = $clog2(SCREEN_WIDTH + 1);
   localparam int Y_W = $clog2(SCREEN_HEIGHT + 1);
   localparam logic [X_W-1:0]    X_LIM     = X_W'(SCREEN_WIDTH);
   localparam logic [Y_W-1:0]    Y_LIM     = Y_W'(SCREEN_HEIGHT);
   localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(SCREEN_WIDTH);

   cap_state_t        state_r;
   logic [7:0]        hi_r;
   logic [X_W-1:0]    x_r;
   logic [Y_W-1:0]    y_r;
   logic [7:0]        y_total_r;
   logic [ADDR_W-1:0] base_r;
   logic [7:0]        pixel_r;
   logic [ADDR_W-1:0] addr_r;
   logic              w_en_r;
   logic              frame_done_r;
   logic [7:0]        frame_lines_r;
   logic [7:0]        pix_s;
   logic              line_end_s;

`ifdef CAMERA_CAPTURE_TEST_PATTERN_EN
   camera_capture_pattern #(
      .SCREEN_WIDTH (SCREEN_WIDTH),
      .X_W          (X_W)
   ) u_pattern (
      .x_s     (x_r),
      .pixel_s (pix_s)
   );

   logic unused_cam_s;
   assign unused_cam_s = ^{CAM_DATA, hi_r};
`else
   assign pix_s = rgb565_to_rgb332(hi_r, CAM_DATA);
`endif

   assign line_end_s = ((state_r == ST_BYTE_HI) || (state_r == ST_BYTE_LO)) && !HREF;

   // Framing FSM, counters and registered frame-buffer write port.
   always_ff @(posedge CLK or negedge RESET_NEG) begin
      if (!RESET_NEG) begin
         state_r       <= ST_SYNC;
         hi_r          <= 8'h00;
         x_r           <= '0;
         y_r           <= '0;
         y_total_r     <= 8'h00;
         base_r        <= '0;
         pixel_r       <= 8'h00;
         addr_r        <= '0;
         w_en_r        <= 1'b0;
         frame_done_r  <= 1'b0;
         frame_lines_r <= 8'h00;
      end else begin
         w_en_r       <= 1'b0;
         frame_done_r <= 1'b0;
         if ((state_r != ST_SYNC) && VSYNC) begin
            // Vertical sync wins over HREF and abandons any partial line.
            x_r       <= '0;
            y_r       <= '0;
            y_total_r <= 8'h00;
            base_r    <= '0;
            if (y_total_r != 8'h00) begin
               frame_done_r  <= 1'b1;
               frame_lines_r <= y_total_r;
            end
            state_r <= ST_VBLANK;
         end else if (line_end_s) begin
            x_r <= '0;
            if (x_r != '0) begin
               if (y_r < Y_LIM) begin
                  y_r    <= y_r + 1'b1;
                  base_r <= base_r + LINE_STEP;
               end
               if (y_total_r != 8'hFF) begin
                  y_total_r <= y_total_r + 8'd1;
               end
            end
            state_r <= ST_HBLANK;
         end else begin
            case (state_r)
               ST_SYNC: begin
                  if (VSYNC) begin
                     state_r <= ST_VBLANK;
                  end
               end
               ST_VBLANK: state_r <= ST_HBLANK;
               ST_HBLANK, ST_BYTE_HI: begin
                  if (HREF) begin
                     hi_r    <= CAM_DATA;
                     state_r <= ST_BYTE_LO;
                  end
               end
               ST_BYTE_LO: begin
                  if ((x_r < X_LIM) && (y_r < Y_LIM)) begin
                     w_en_r  <= 1'b1;
                     pixel_r <= pix_s;
                     addr_r  <= base_r + ADDR_W'(x_r);
                  end
                  if (x_r < X_LIM) begin
                     x_r <= x_r + 1'b1;
                  end
                  state_r <= ST_BYTE_HI;
               end
               default: state_r <= ST_SYNC;
            endcase
         end
      end
   end

   assign PIXEL_OUT   = pixel_r;
   assign W_ADDR      = addr_r;
   assign W_EN        = w_en_r;
   assign FRAME_DONE  = frame_done_r;
   assign FRAME_LINES = frame_lines_r;

endmodule
